// File: rtl/im_fetch_ctrl_pkg.sv
// Shared fetch definitions: architecture widths, IM geometry, PC step, fetch state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Ports: none. Macros are guarded so repeated inclusion in one compilation unit is harmless.

`ifndef IM_FETCH_ARCH_DEF
`define IM_FETCH_ARCH_DEF
`define ARCH_WIDTH   32
`define IM_WIDTH     32
`define IM_DEPTH     10
`define IM_SIZE      1024
`define IM_ADDR_BASE 32'h0000_3000
`define PC_STEP      4
`define FS_BOOT      2'd0
`define FS_FETCH     2'd1
`define FS_FAULT     2'd2
`endif

package im_fetch_ctrl_pkg;

    localparam int ARCH_W  = `ARCH_WIDTH;
    localparam int INSTR_W = `IM_WIDTH;

    typedef enum logic [1:0] {
        S_BOOT  = `FS_BOOT,
        S_FETCH = `FS_FETCH,
        S_FAULT = `FS_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [ARCH_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [ARCH_W-1:0] align_pc(input logic [ARCH_W-1:0] a);
        return a & ~ARCH_W'(3);
    endfunction

endpackage

// File: rtl/im_fetch_ctrl_fetch_buf.sv
// In-order {pc, instr} buffer between IM fetch and decode, with flush.
// Latency: one cycle from push to head (registered, no bypass).
// Backpressure: caller must not push when full; flush overrides push and pop.
// Ports: clk, rst (async high), i_push/i_pop/i_flush controls, i_dat entry in,
//        o_count occupancy, o_head head entry (zero when empty).

module im_fetch_ctrl_fetch_buf
    import im_fetch_ctrl_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int PW        = $clog2(BUF_DEPTH),
    parameter int CW        = $clog2(BUF_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_dat,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [BUF_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (i_pop && !i_push) r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
    end

    assign o_count = r_count;
    // Head reads as zero when empty so out_pc/out_instr are clean after reset and flush.
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads IM, buffers {pc, instr} for decode.
// Latency: instr at PC X is on out_* one cycle after X is on im_addr; 1 instr/cycle steady state.
// Backpressure: out_ready low fills the buffer, then the PC holds; redirect flushes everything.
// Ports: clk, rst (async high); im_addr/im_dout to the combinational IM; redirect_valid/redirect_pc;
//        out_valid/out_ready/out_instr/out_pc to decode; fault.
// Optional: IM_BOUND_CHECK_EN adds the FAULT state for PCs outside the IM window; otherwise fault=0.

module im_fetch_ctrl
    import im_fetch_ctrl_pkg::*;
#(
    parameter logic [`ARCH_WIDTH-1:0] RESET_PC  = `IM_ADDR_BASE,
    parameter int                     BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [`ARCH_WIDTH-1:0] im_addr,
    input  logic [`IM_WIDTH-1:0]   im_dout,
    input  logic                   redirect_valid,
    input  logic [`ARCH_WIDTH-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`IM_WIDTH-1:0]   out_instr,
    output logic [`ARCH_WIDTH-1:0] out_pc,
    output logic                   fault
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ARCH_W-1:0] r_pc;
    logic [ARCH_W-1:0] w_pc_nxt;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count;
    logic              w_not_full;
    fetch_entry_t      w_head;
    fetch_entry_t      w_entry;

`ifdef IM_BOUND_CHECK_EN
    logic [ARCH_W-1:0] w_pc_off;
    logic              w_oob;
    // Unsigned offset compare also catches PCs below the base (they wrap to huge offsets).
    assign w_pc_off = r_pc - `IM_ADDR_BASE;
    assign w_oob    = (w_pc_off >= ARCH_W'(`IM_SIZE * 4));
`endif

    // Fullness uses the registered count only: no push-through-full on a same-cycle pop.
    assign w_not_full = (w_count < CW'(BUF_DEPTH));
    assign w_pop      = out_valid && out_ready && !redirect_valid;
    assign w_entry    = '{pc: r_pc, instr: im_dout};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_BOOT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        if (redirect_valid) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = align_pc(redirect_pc);
        end else begin
            case (r_state)
                S_BOOT: w_state_nxt = S_FETCH;
                S_FETCH: begin
`ifdef IM_BOUND_CHECK_EN
                    if (w_oob) w_state_nxt = S_FAULT;
                    else
`endif
                    if (w_not_full) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + ARCH_W'(`PC_STEP);
                    end
                end
`ifdef IM_BOUND_CHECK_EN
                S_FAULT: w_state_nxt = S_FAULT;
`endif
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_pc_nxt;
    end

    im_fetch_ctrl_fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_dat   (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign im_addr   = r_pc;
    assign out_valid = (w_count != '0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

`ifdef IM_BOUND_CHECK_EN
    assign fault = (r_state == S_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Bench for im_fetch_ctrl: directed stimulus, expected PCs queued, monitor checks every handshake.
// Latency: n/a.
// Backpressure: out_ready is driven directly by the stimulus.

module tb_im_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] im_addr;
    logic [31:0] im_dout;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    im_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .im_addr        (im_addr),
        .im_dout        (im_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IM contents: word k above base 0x3000 holds 0xA0 + k.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h3000) >> 2);
    endfunction

    assign im_dout = im_word(im_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a handshake in a redirect cycle is not a delivery.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h expected=none", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_instr", out_instr, im_word(e));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) step();
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_im_addr", im_addr, 32'h3000);

        // Boot and streaming
        rst = 1'b0;
        step();
        chk("boot_im_addr", im_addr, 32'h3000);
        chk("boot_valid", {31'b0, out_valid}, 32'h0);
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        exp_q.push_back(32'h3008);
        step();
        chk("first_valid", {31'b0, out_valid}, 32'h1);
        chk("first_pc", out_pc, 32'h3000);
        step();
        chk("stream_pc1", out_pc, 32'h3004);
        step();
        chk("stream_pc2", out_pc, 32'h3008);
        step();

        // Restart at base, then stall with out_ready low
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        out_ready      = 1'b0;
        step();
        redirect_valid = 1'b0;
        chk("rd0_valid", {31'b0, out_valid}, 32'h0);
        chk("rd0_im_addr", im_addr, 32'h3000);
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        exp_q.push_back(32'h3008);
        step();
        chk("rd0_first_pc", out_pc, 32'h3000);
        repeat (4) step();
        chk("stall_instr", out_instr, 32'hA0);
        chk("stall_im_addr", im_addr, 32'h3008);
        chk("stall_valid", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        step();
        chk("drain_pc1", out_pc, 32'h3004);
        step();
        chk("drain_pc2", out_pc, 32'h3008);
        step();
        out_ready = 1'b0;
        step();
        chk("full_im_addr", im_addr, 32'h3014);

        // Redirect while full, misaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3043;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("rd1_valid", {31'b0, out_valid}, 32'h0);
        chk("rd1_im_addr", im_addr, 32'h3040);
        exp_q.push_back(32'h3040);
        step();
        chk("rd1_first_pc", out_pc, 32'h3040);
        step();
        chk("rd1_second_pc", out_pc, 32'h3044);

        // Redirect coinciding with a pop and a push
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3100;
        step();
        redirect_valid = 1'b0;
        chk("rd2_valid", {31'b0, out_valid}, 32'h0);
        chk("rd2_im_addr", im_addr, 32'h3100);
        exp_q.push_back(32'h3100);
        step();
        chk("rd2_first_pc", out_pc, 32'h3100);
        step();

`ifndef IM_BOUND_CHECK_EN
        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_valid", {31'b0, out_valid}, 32'h0);
        chk("wrap_im_addr0", im_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        step();
        chk("wrap_im_addr1", im_addr, 32'h0);
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_fault", {31'b0, fault}, 32'h0);
        step();
        chk("wrap_pc_zero", out_pc, 32'h0);
        step();
        out_ready = 1'b0;
`else
        // Last in-range word, then fault, then recovery
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FFC;
        step();
        redirect_valid = 1'b0;
        chk("bnd_valid", {31'b0, out_valid}, 32'h0);
        exp_q.push_back(32'h3FFC);
        step();
        chk("bnd_last_pc", out_pc, 32'h3FFC);
        chk("bnd_fault0", {31'b0, fault}, 32'h0);
        step();
        chk("bnd_fault1", {31'b0, fault}, 32'h1);
        chk("bnd_drained", {31'b0, out_valid}, 32'h0);
        chk("bnd_im_addr", im_addr, 32'h4000);
        step();
        chk("bnd_fault_hold", {31'b0, fault}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        step();
        redirect_valid = 1'b0;
        chk("bnd_fault_clr", {31'b0, fault}, 32'h0);
        chk("bnd_rec_valid", {31'b0, out_valid}, 32'h0);
        exp_q.push_back(32'h3000);
        step();
        chk("bnd_rec_pc", out_pc, 32'h3000);
        step();
        out_ready = 1'b0;
`endif

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
